// File: rtl/op_control_fsm_multi.sv
// Multi-channel operation control FSM: round-robin start arbitration, timed datapath
// reset pulse, critical section guarded by a watchdog, and a completed-operation counter.
module op_control_fsm_multi #(
  parameter int NUM_CH       = 4,
  parameter int RESET_CYCLES = 1,
  parameter int TIMEOUT      = 1000,
  parameter int CNT_W        = 16,
  localparam int IDX_W       = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [NUM_CH-1:0] startOp,
  input  logic              finishedOp,
  input  logic              abortOp,
  output logic              resetEverything,
  output logic              readyNextOp,
  output logic              critical,
  output logic [NUM_CH-1:0] grantOh,
  output logic [IDX_W-1:0]  grantIdx,
  output logic              opDone,
  output logic              opTimeout,
  output logic              errSticky,
  output logic [CNT_W-1:0]  opCount
);

  localparam int              WD_W     = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
  localparam logic [WD_W-1:0] WD_LAST  = WD_W'((TIMEOUT > 0) ? (TIMEOUT - 1) : 0);
  localparam bit              WD_EN    = (TIMEOUT != 0);
  localparam logic [7:0]      RST_LOAD = 8'(RESET_CYCLES - 1);
  localparam logic [IDX_W:0]  NUM_CH_X = (IDX_W + 1)'(NUM_CH);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RST  = 2'd1,
    RUN  = 2'd2,
    DONE = 2'd3
  } state_e;

  state_e            state_q, state_d;
  logic [NUM_CH-1:0] grant_oh_q, grant_oh_d;
  logic [IDX_W-1:0]  grant_idx_q, grant_idx_d;
  logic [7:0]        rst_cnt_q, rst_cnt_d;
  logic [WD_W-1:0]   wd_q, wd_d;
  logic              op_timeout_q, op_timeout_d;
  logic              err_q, err_d;
  logic [CNT_W-1:0]  op_count_q, op_count_d;
  logic [IDX_W:0]    pick;

  // Returns {found, index}: first requester at or after last+1, wrapping; lowest offset wins.
  function automatic logic [IDX_W:0] rr_pick(input logic [NUM_CH-1:0] req,
                                             input logic [IDX_W-1:0]  last);
    logic [IDX_W:0] res;
    logic [IDX_W:0] cand;
    res = {(IDX_W + 1){1'b0}};
    for (int i = NUM_CH; i >= 1; i--) begin
      cand = {1'b0, last} + (IDX_W + 1)'(i);
      cand = (cand >= NUM_CH_X) ? (cand - NUM_CH_X) : cand;
      res  = req[cand[IDX_W-1:0]] ? {1'b1, cand[IDX_W-1:0]} : res;
    end
    return res;
  endfunction

  // Next-state and next-output computation.
  always_comb begin
    pick         = rr_pick(startOp, grant_idx_q);
    state_d      = state_q;
    grant_oh_d   = grant_oh_q;
    grant_idx_d  = grant_idx_q;
    rst_cnt_d    = rst_cnt_q;
    wd_d         = wd_q;
    op_timeout_d = 1'b0;
    err_d        = err_q;
    op_count_d   = op_count_q;
    case (state_q)
      IDLE: begin
        if (pick[IDX_W]) begin
          state_d     = RST;
          grant_idx_d = pick[IDX_W-1:0];
          grant_oh_d  = NUM_CH'(1'b1) << pick[IDX_W-1:0];
          rst_cnt_d   = RST_LOAD;
        end else begin
          state_d     = IDLE;
        end
      end
      RST: begin
        if (abortOp) begin
          state_d    = IDLE;
          grant_oh_d = {NUM_CH{1'b0}};
        end else if (rst_cnt_q == 8'd0) begin
          state_d    = RUN;
          wd_d       = {WD_W{1'b0}};
        end else begin
          rst_cnt_d  = rst_cnt_q - 8'd1;
        end
      end
      // Priority inside the critical section: abort, then watchdog, then completion.
      RUN: begin
        if (abortOp) begin
          state_d      = IDLE;
          grant_oh_d   = {NUM_CH{1'b0}};
        end else if (WD_EN && (wd_q == WD_LAST)) begin
          state_d      = IDLE;
          grant_oh_d   = {NUM_CH{1'b0}};
          op_timeout_d = 1'b1;
          err_d        = 1'b1;
        end else if (finishedOp) begin
          state_d      = DONE;
          op_count_d   = op_count_q + CNT_W'(1'b1);
        end else begin
          wd_d         = wd_q + WD_W'(1'b1);
        end
      end
      DONE: begin
        state_d    = IDLE;
        grant_oh_d = {NUM_CH{1'b0}};
      end
      default: begin
        state_d    = IDLE;
        grant_oh_d = {NUM_CH{1'b0}};
      end
    endcase
  end

  // State and output registers; reset wins over every event.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= IDLE;
      grant_oh_q   <= {NUM_CH{1'b0}};
      grant_idx_q  <= IDX_W'(NUM_CH - 1);
      rst_cnt_q    <= 8'd0;
      wd_q         <= {WD_W{1'b0}};
      op_timeout_q <= 1'b0;
      err_q        <= 1'b0;
      op_count_q   <= {CNT_W{1'b0}};
    end else begin
      state_q      <= state_d;
      grant_oh_q   <= grant_oh_d;
      grant_idx_q  <= grant_idx_d;
      rst_cnt_q    <= rst_cnt_d;
      wd_q         <= wd_d;
      op_timeout_q <= op_timeout_d;
      err_q        <= err_d;
      op_count_q   <= op_count_d;
    end
  end

  assign resetEverything = (state_q == RST);
  assign readyNextOp     = (state_q == IDLE);
  assign critical        = (state_q == RST) || (state_q == RUN);
  assign opDone          = (state_q == DONE);
  assign grantOh         = grant_oh_q;
  assign grantIdx        = grant_idx_q;
  assign opTimeout       = op_timeout_q;
  assign errSticky       = err_q;
  assign opCount         = op_count_q;

endmodule

// File: tb/tb_op_control_fsm_multi.sv
// Bench for op_control_fsm_multi: directed scenarios plus random traffic, all compared
// against a phase-counting reference model of the operation lifecycle.
module tb_op_control_fsm_multi;

  localparam int NUM_CH       = 4;
  localparam int RESET_CYCLES = 4;
  localparam int TIMEOUT      = 8;
  localparam int CNT_W        = 4;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [3:0]  startOp = 4'b0000;
  logic        finishedOp = 1'b0;
  logic        abortOp = 1'b0;
  logic        resetEverything, readyNextOp, critical, opDone, opTimeout, errSticky;
  logic [3:0]  grantOh;
  logic [1:0]  grantIdx;
  logic [3:0]  opCount;
  logic [15:0] dut_vec;

  int errors = 0;
  int checks = 0;

  // Reference model: remaining reset-pulse cycles, cycles spent running, owner channel.
  int m_reset_left = 0;
  int m_run_cycles = 0;
  int m_owner      = -1;
  int m_last       = NUM_CH - 1;
  int m_count      = 0;
  bit m_in_run     = 1'b0;
  bit m_done       = 1'b0;
  bit m_to         = 1'b0;
  bit m_err        = 1'b0;

  always #5 clk = ~clk;

  op_control_fsm_multi #(
    .NUM_CH(NUM_CH), .RESET_CYCLES(RESET_CYCLES), .TIMEOUT(TIMEOUT), .CNT_W(CNT_W)
  ) dut (
    .clk(clk), .reset(reset), .startOp(startOp), .finishedOp(finishedOp), .abortOp(abortOp),
    .resetEverything(resetEverything), .readyNextOp(readyNextOp), .critical(critical),
    .grantOh(grantOh), .grantIdx(grantIdx), .opDone(opDone), .opTimeout(opTimeout),
    .errSticky(errSticky), .opCount(opCount)
  );

  assign dut_vec = {resetEverything, readyNextOp, critical, grantOh, grantIdx,
                    opDone, opTimeout, errSticky, opCount};

  function automatic logic [15:0] exp_vec();
    logic       rst_o, crit, rdy;
    logic [3:0] oh;
    rst_o = (m_reset_left > 0);
    crit  = rst_o || m_in_run;
    rdy   = !crit && !m_done;
    oh    = (m_owner >= 0) ? 4'(1 << m_owner) : 4'b0000;
    return {rst_o, rdy, crit, oh, 2'(m_last), m_done, m_to, m_err, 4'(m_count)};
  endfunction

  task automatic model_step();
    bit to_n;
    int c;
    to_n = 1'b0;
    if (reset) begin
      m_reset_left = 0; m_run_cycles = 0; m_in_run = 1'b0; m_done = 1'b0;
      m_owner = -1; m_last = NUM_CH - 1; m_count = 0; m_err = 1'b0;
    end else if (m_done) begin
      m_done = 1'b0; m_owner = -1;
    end else if (m_reset_left > 0) begin
      if (abortOp) begin
        m_reset_left = 0; m_owner = -1;
      end else begin
        m_reset_left--;
        if (m_reset_left == 0) begin
          m_in_run = 1'b1; m_run_cycles = 0;
        end
      end
    end else if (m_in_run) begin
      if (abortOp) begin
        m_in_run = 1'b0; m_owner = -1;
      end else if (TIMEOUT != 0 && m_run_cycles == TIMEOUT - 1) begin
        m_in_run = 1'b0; m_owner = -1; to_n = 1'b1; m_err = 1'b1;
      end else if (finishedOp) begin
        m_in_run = 1'b0; m_done = 1'b1; m_count = (m_count + 1) % (1 << CNT_W);
      end else begin
        m_run_cycles++;
      end
    end else if (startOp != 4'b0000) begin
      for (int k = 1; k <= NUM_CH; k++) begin
        c = (m_last + k) % NUM_CH;
        if (startOp[2'(c)] && m_owner < 0) m_owner = c;
      end
      m_last = m_owner;
      m_reset_left = RESET_CYCLES;
    end
    m_to = to_n;
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    @(negedge clk);
  endtask

  task automatic do_reset();
    startOp = 4'b0000; finishedOp = 1'b0; abortOp = 1'b0;
    reset = 1'b1;
    tick();
    reset = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    tick();
    tick();
    checks++;
    if (dut_vec !== exp_vec()) begin
      errors++; $display("FAIL reset_vec: got %h expected %h", dut_vec, exp_vec());
    end
    checks++;
    if (readyNextOp !== 1'b1 || grantIdx !== 2'd3 || grantOh !== 4'b0000 || opCount !== 4'd0) begin
      errors++; $display("FAIL reset_vals: got rdy=%b idx=%0d oh=%b cnt=%0d expected 1 3 0000 0",
                         readyNextOp, grantIdx, grantOh, opCount);
    end
    reset = 1'b0;
  endtask

  task automatic test_single();
    int re_cyc, crit_cyc, done_cnt;
    re_cyc = 0; crit_cyc = 0; done_cnt = 0;
    do_reset();
    for (int t = 0; t < 16; t++) begin
      startOp    = (t == 0) ? 4'b0001 : 4'b0000;
      finishedOp = (t == RESET_CYCLES + 5);
      tick();
      checks++;
      if (dut_vec !== exp_vec()) begin
        errors++; $display("FAIL single_vec t=%0d: got %h expected %h", t, dut_vec, exp_vec());
      end
      re_cyc   += int'(resetEverything);
      crit_cyc += int'(critical);
      done_cnt += int'(opDone);
    end
    finishedOp = 1'b0;
    checks++;
    if (re_cyc != RESET_CYCLES || crit_cyc != RESET_CYCLES + 5) begin
      errors++; $display("FAIL single_len: got reset=%0d crit=%0d expected %0d %0d",
                         re_cyc, crit_cyc, RESET_CYCLES, RESET_CYCLES + 5);
    end
    checks++;
    if (done_cnt != 1 || opCount !== 4'd1 || grantIdx !== 2'd0) begin
      errors++; $display("FAIL single_done: got done=%0d cnt=%0d idx=%0d expected 1 1 0",
                         done_cnt, opCount, grantIdx);
    end
  endtask

  task automatic test_round_robin();
    int order [5];
    int n_done;
    order = '{0, 1, 2, 3, 0};
    n_done = 0;
    do_reset();
    startOp = 4'b1111;
    for (int t = 0; t < 200 && n_done < 5; t++) begin
      finishedOp = m_in_run && (m_run_cycles == 1);
      tick();
      checks++;
      if (dut_vec !== exp_vec()) begin
        errors++; $display("FAIL rr_vec t=%0d: got %h expected %h", t, dut_vec, exp_vec());
      end
      if (opDone) begin
        checks++;
        if (grantIdx !== 2'(order[n_done])) begin
          errors++; $display("FAIL rr_order op=%0d: got %0d expected %0d", n_done, grantIdx, order[n_done]);
        end
        n_done++;
      end
    end
    startOp = 4'b0000; finishedOp = 1'b0;
    checks++;
    if (n_done != 5 || opCount !== 4'd5) begin
      errors++; $display("FAIL rr_count: got ops=%0d cnt=%0d expected 5 5", n_done, opCount);
    end
  endtask

  task automatic test_finish_in_rst();
    int re_cyc;
    re_cyc = 0;
    do_reset();
    startOp = 4'b0100;
    tick();
    startOp = 4'b0000;
    re_cyc += int'(resetEverything);
    for (int t = 0; t < RESET_CYCLES + 3; t++) begin
      finishedOp = (m_reset_left > 0);
      tick();
      checks++;
      if (dut_vec !== exp_vec()) begin
        errors++; $display("FAIL rstfin_vec t=%0d: got %h expected %h", t, dut_vec, exp_vec());
      end
      re_cyc += int'(resetEverything);
    end
    checks++;
    if (re_cyc != RESET_CYCLES || critical !== 1'b1 || resetEverything !== 1'b0 ||
        opDone !== 1'b0 || grantOh !== 4'b0100) begin
      errors++; $display("FAIL rstfin_hold: got reset=%0d crit=%b done=%b oh=%b expected %0d 1 0 0100",
                         re_cyc, critical, opDone, grantOh, RESET_CYCLES);
    end
    finishedOp = 1'b1;
    tick();
    finishedOp = 1'b0;
    checks++;
    if (opDone !== 1'b1 || opCount !== 4'd1 || critical !== 1'b0) begin
      errors++; $display("FAIL rstfin_done: got done=%b cnt=%0d crit=%b expected 1 1 0",
                         opDone, opCount, critical);
    end
  endtask

  task automatic test_timeout();
    int run_len, to_cnt;
    run_len = 0; to_cnt = 0;
    do_reset();
    startOp = 4'b0001;
    tick();
    startOp = 4'b0000;
    for (int t = 0; t < 20; t++) begin
      tick();
      checks++;
      if (dut_vec !== exp_vec()) begin
        errors++; $display("FAIL to_vec t=%0d: got %h expected %h", t, dut_vec, exp_vec());
      end
      run_len += int'(critical && !resetEverything);
      to_cnt  += int'(opTimeout);
    end
    checks++;
    if (run_len != TIMEOUT || to_cnt != 1 || errSticky !== 1'b1 || opCount !== 4'd0) begin
      errors++; $display("FAIL to_basic: got run=%0d pulses=%0d err=%b cnt=%0d expected %0d 1 1 0",
                         run_len, to_cnt, errSticky, opCount, TIMEOUT);
    end
    startOp = 4'b0010;
    tick();
    startOp = 4'b0000;
    for (int t = 0; t < 12; t++) begin
      finishedOp = m_in_run;
      tick();
      checks++;
      if (dut_vec !== exp_vec()) begin
        errors++; $display("FAIL to_next_vec t=%0d: got %h expected %h", t, dut_vec, exp_vec());
      end
    end
    finishedOp = 1'b0;
    checks++;
    if (errSticky !== 1'b1 || opCount !== 4'd1) begin
      errors++; $display("FAIL to_sticky: got err=%b cnt=%0d expected 1 1", errSticky, opCount);
    end
  endtask

  task automatic test_abort();
    do_reset();
    startOp = 4'b0001;
    tick();
    startOp = 4'b0000;
    tick();
    abortOp = 1'b1;
    tick();
    abortOp = 1'b0;
    checks++;
    if (dut_vec !== exp_vec() || readyNextOp !== 1'b1 || grantOh !== 4'b0000 || opDone !== 1'b0) begin
      errors++; $display("FAIL abort_rst: got %h expected %h", dut_vec, exp_vec());
    end
    startOp = 4'b1000;
    tick();
    startOp = 4'b0000;
    for (int t = 0; t < RESET_CYCLES; t++) tick();
    checks++;
    if (critical !== 1'b1 || resetEverything !== 1'b0 || grantOh !== 4'b1000) begin
      errors++; $display("FAIL abort_setup: got crit=%b rst=%b oh=%b expected 1 0 1000",
                         critical, resetEverything, grantOh);
    end
    abortOp = 1'b1; finishedOp = 1'b1;
    tick();
    abortOp = 1'b0; finishedOp = 1'b0;
    checks++;
    if (dut_vec !== exp_vec() || readyNextOp !== 1'b1 || opDone !== 1'b0 ||
        grantOh !== 4'b0000 || opCount !== 4'd0) begin
      errors++; $display("FAIL abort_run: got %h expected %h", dut_vec, exp_vec());
    end
    tick();
    checks++;
    if (opDone !== 1'b0 || opCount !== 4'd0) begin
      errors++; $display("FAIL abort_late: got done=%b cnt=%0d expected 0 0", opDone, opCount);
    end
  endtask

  task automatic test_reset_mid_run();
    do_reset();
    startOp = 4'b0001;
    tick();
    startOp = 4'b0000;
    for (int t = 0; t < 8; t++) begin
      finishedOp = m_in_run;
      tick();
    end
    finishedOp = 1'b0;
    startOp = 4'b0001;
    tick();
    startOp = 4'b0000;
    for (int t = 0; t < 14; t++) tick();
    checks++;
    if (opCount !== 4'd1 || errSticky !== 1'b1) begin
      errors++; $display("FAIL midrst_setup: got cnt=%0d err=%b expected 1 1", opCount, errSticky);
    end
    startOp = 4'b0010;
    for (int t = 0; t < RESET_CYCLES + 3; t++) tick();
    checks++;
    if (dut_vec !== exp_vec() || critical !== 1'b1) begin
      errors++; $display("FAIL midrst_run: got %h expected %h", dut_vec, exp_vec());
    end
    reset = 1'b1;
    tick();
    reset = 1'b0;
    checks++;
    if (readyNextOp !== 1'b1 || opCount !== 4'd0 || errSticky !== 1'b0 ||
        critical !== 1'b0 || grantOh !== 4'b0000 || opTimeout !== 1'b0) begin
      errors++; $display("FAIL midrst_idle: got %h expected %h", dut_vec, exp_vec());
    end
    tick();
    checks++;
    if (grantIdx !== 2'd1 || grantOh !== 4'b0010 || resetEverything !== 1'b1) begin
      errors++; $display("FAIL midrst_regrant: got idx=%0d oh=%b rst=%b expected 1 0010 1",
                         grantIdx, grantOh, resetEverything);
    end
    startOp = 4'b0000;
  endtask

  task automatic test_random();
    do_reset();
    for (int t = 0; t < 3000; t++) begin
      startOp    = 4'($urandom_range(0, 15));
      finishedOp = ($urandom_range(0, 3) == 0);
      abortOp    = ($urandom_range(0, 31) == 0);
      reset      = ($urandom_range(0, 199) == 0);
      tick();
      checks++;
      if (dut_vec !== exp_vec()) begin
        errors++; $display("FAIL rand_vec t=%0d: got %h expected %h", t, dut_vec, exp_vec());
      end
    end
    reset = 1'b0; startOp = 4'b0000; finishedOp = 1'b0; abortOp = 1'b0;
  endtask

  initial begin
    test_reset();
    test_single();
    test_round_robin();
    test_finish_in_rst();
    test_timeout();
    test_abort();
    test_reset_mid_run();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
